// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source/observer and the pwm_capture block.
interface pwm_capture_if #(
   parameter int CNT_W = 16
);
   logic             pwm_in;
   logic             clr;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic [6:0]       duty_pct;
   logic             valid;
   logic             stuck;
   logic             ovr;

   modport master (
      output pwm_in, clr,
      input  high_cnt, period_cnt, duty_pct, valid, stuck, ovr
   );

   modport slave (
      input  pwm_in, clr,
      output high_cnt, period_cnt, duty_pct, valid, stuck, ovr
   );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwm_in, derives duty percent
// with a restoring divider, and flags stuck inputs and dropped periods.
//
// state     | meaning
// WAIT_RISE | idle / after timeout or clear; waiting for first rising edge
// MEAS_HI   | input high; counting high time and period
// MEAS_LO   | input low; counting period until the rise that closes it
module pwm_capture #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic         clk,
   input  logic         rst_n,
   pwm_capture_if.slave cap
);
   localparam int DIV_W  = CNT_W + 7;
   localparam int STEP_W = $clog2(DIV_W + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [CNT_W-1:0]  TO_LOAD = CNT_W'(TIMEOUT);
   localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(DIV_W);

   typedef enum logic [1:0] {WAIT_RISE, MEAS_HI, MEAS_LO} state_t;

   state_t              r_state;
   logic                r_sync1, r_sync2, r_sync3;
   logic [CNT_W-1:0]    r_hi_ctr, r_per_ctr;
   logic [CNT_W-1:0]    r_cap_hi, r_cap_per;
   logic [CNT_W-1:0]    r_to_ctr;
   logic                r_div_busy;
   logic [STEP_W-1:0]   r_div_step;
   logic [CNT_W-1:0]    r_rem;
   logic [DIV_W-1:0]    r_quo;
   logic [CNT_W-1:0]    r_high_cnt, r_period_cnt;
   logic [6:0]          r_duty;
   logic                r_valid, r_stuck, r_ovr;

   logic                w_rise, w_fall, w_edge, w_to_fire;
   logic [CNT_W:0]      w_rem_sh;
   logic                w_ge;
   logic [CNT_W-1:0]    w_rem_sub;
   logic [DIV_W-1:0]    w_quo_nx;
   logic [DIV_W-1:0]    w_dividend;
   logic [6:0]          w_done_duty;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   assign w_rise    = r_sync2 & ~r_sync3;
   assign w_fall    = ~r_sync2 & r_sync3;
   assign w_edge    = w_rise | w_fall;
   // Down-counter parks at zero after firing so a stuck input reports once.
   assign w_to_fire = ~w_edge && (r_to_ctr == CNT_W'(1));

   // One restoring-division step: remainder stays below the divisor, so the
   // subtraction fits in CNT_W bits.
   assign w_rem_sh    = {r_rem, r_quo[DIV_W-1]};
   assign w_ge        = (w_rem_sh >= {1'b0, r_cap_per});
   assign w_rem_sub   = w_rem_sh[CNT_W-1:0] - r_cap_per;
   assign w_quo_nx    = {r_quo[DIV_W-2:0], w_ge};
   assign w_dividend  = DIV_W'(r_hi_ctr) * DIV_W'(100);
   assign w_done_duty = (r_cap_per == '0) ? 7'd0 : w_quo_nx[6:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= WAIT_RISE;
         r_sync1      <= 1'b0;
         r_sync2      <= 1'b0;
         r_sync3      <= 1'b0;
         r_hi_ctr     <= '0;
         r_per_ctr    <= '0;
         r_cap_hi     <= '0;
         r_cap_per    <= '0;
         r_to_ctr     <= TO_LOAD;
         r_div_busy   <= 1'b0;
         r_div_step   <= '0;
         r_rem        <= '0;
         r_quo        <= '0;
         r_high_cnt   <= '0;
         r_period_cnt <= '0;
         r_duty       <= '0;
         r_valid      <= 1'b0;
         r_stuck      <= 1'b0;
         r_ovr        <= 1'b0;
      end else begin
         r_sync1 <= cap.pwm_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_valid <= 1'b0;
         if (cap.clr) begin
            r_state      <= WAIT_RISE;
            r_hi_ctr     <= '0;
            r_per_ctr    <= '0;
            r_to_ctr     <= TO_LOAD;
            r_div_busy   <= 1'b0;
            r_div_step   <= '0;
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
            r_duty       <= '0;
            r_stuck      <= 1'b0;
            r_ovr        <= 1'b0;
         end else begin
            if (w_edge)
               r_to_ctr <= TO_LOAD;
            else if (r_to_ctr != '0)
               r_to_ctr <= r_to_ctr - 1'b1;

            if (r_div_busy) begin
               r_rem      <= w_ge ? w_rem_sub : w_rem_sh[CNT_W-1:0];
               r_quo      <= w_quo_nx;
               r_div_step <= r_div_step - 1'b1;
               if (r_div_step == STEP_W'(1)) begin
                  r_div_busy   <= 1'b0;
                  r_high_cnt   <= r_cap_hi;
                  r_period_cnt <= r_cap_per;
                  r_duty       <= w_done_duty;
                  r_valid      <= 1'b1;
                  r_stuck      <= 1'b0;
               end
            end

            case (r_state)
               WAIT_RISE: begin
                  if (w_rise) begin
                     r_hi_ctr  <= CNT_W'(1);
                     r_per_ctr <= CNT_W'(1);
                     r_state   <= MEAS_HI;
                  end
               end
               MEAS_HI: begin
                  r_per_ctr <= sat_inc(r_per_ctr);
                  if (w_fall)
                     r_state <= MEAS_LO;
                  else
                     r_hi_ctr <= sat_inc(r_hi_ctr);
               end
               MEAS_LO: begin
                  if (w_rise) begin
                     // A busy divider keeps its result; this period is dropped.
                     if (!r_div_busy) begin
                        r_cap_hi   <= r_hi_ctr;
                        r_cap_per  <= r_per_ctr;
                        r_rem      <= '0;
                        r_quo      <= w_dividend;
                        r_div_step <= STEP_LOAD;
                        r_div_busy <= 1'b1;
                     end else begin
                        r_ovr <= 1'b1;
                     end
                     r_hi_ctr  <= CNT_W'(1);
                     r_per_ctr <= CNT_W'(1);
                     r_state   <= MEAS_HI;
                  end else begin
                     r_per_ctr <= sat_inc(r_per_ctr);
                  end
               end
               default: r_state <= WAIT_RISE;
            endcase

            if (w_to_fire) begin
               r_state      <= WAIT_RISE;
               r_stuck      <= 1'b1;
               r_high_cnt   <= '0;
               r_period_cnt <= '0;
               r_duty       <= r_sync2 ? 7'd100 : 7'd0;
               r_valid      <= 1'b1;
            end
         end
      end
   end

   assign cap.high_cnt   = r_high_cnt;
   assign cap.period_cnt = r_period_cnt;
   assign cap.duty_pct   = r_duty;
   assign cap.valid      = r_valid;
   assign cap.stuck      = r_stuck;
   assign cap.ovr        = r_ovr;
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its high time, period and duty cycle in percent. It is the receive-side counterpart to the breathing-LED PWM generator: it closes the loop on generated PWM for self-test, and it reads external PWM such as a dimmer input in the alarm design. It synchronises the input, runs a measurement FSM, and uses a sequential divider to compute the duty percentage.

## Interface

Parameters:
- CNT_W, 16, width of the high-time and period counters.
- TIMEOUT, 50000, clk cycles without an edge before the input is declared stuck. Must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pwm_in  in  1  asynchronous PWM input.
- clr  in  1  synchronous clear; aborts measurement and clears flags.
- high_cnt  out  CNT_W  high time of the last complete period, in clk cycles.
- period_cnt  out  CNT_W  last complete period, rise to rise, in clk cycles.
- duty_pct  out  7  floor(high_cnt*100/period_cnt), range 0..100.
- valid  out  1  one-cycle pulse when duty_pct and the counts update.
- stuck  out  1  set on timeout; cleared by the next valid measured period or by clr.
- ovr  out  1  sticky flag: a period was dropped because the divider was busy. Cleared only by clr.

## Operation

Input path:
- pwm_in passes through a 2-FF synchroniser, then a third register for edge detection.
- rise and fall are single-cycle strobes derived from the synchronised signal.

FSM states:
- WAIT_RISE, the reset state: ignore fall; on rise go to MEAS_HI with hi_ctr=1 and per_ctr=1.
- MEAS_HI: increment both counters each cycle; on fall go to MEAS_LO.
- MEAS_LO: increment per_ctr each cycle. On rise:
  - latch hi_ctr and per_ctr into the capture registers;
  - start the divider;
  - reload hi_ctr=1 and per_ctr=1;
  - go to MEAS_HI.

Counter rules:
- Counters saturate at 2^CNT_W-1 and never wrap.

Timeout, checked in MEAS_HI, MEAS_LO and WAIT_RISE:
- Trigger: the cycles since the last edge reach TIMEOUT.
- Outputs: stuck=1, high_cnt=0, period_cnt=0, valid pulses.
- duty_pct is 100 if the synchronised level is high, 0 if low.
- FSM goes to WAIT_RISE.
- While stuck is set, the timeout fires once only; no repeat until an edge occurs.

Divider:
- Restoring division of (high*100), width CNT_W+7, by period.
- Produces one quotient bit per cycle over CNT_W+7 cycles, then outputs update and valid pulses.
- If period==0, the result is 0. This cannot occur in normal operation.
- high_cnt and period_cnt outputs update in the same cycle as duty_pct, so the three values are always coherent.

Divider collision:
- If a rise completes a period while the divider is busy, that period is discarded and ovr=1.
- The counters still reload, and the divider continues undisturbed.

Clear:
- clr takes priority over all events in the same cycle.
- Effects: FSM goes to WAIT_RISE, the divider aborts, and all outputs go to 0.
- The synchroniser is not cleared.

Reset:
- All outputs 0, FSM in WAIT_RISE, synchroniser flops 0.
- Asserting reset mid-measurement or mid-division discards all state.

## Timing

- Input to edge strobe: 3 clk cycles.
- Completing rise to valid: CNT_W+7+1 cycles (24 for CNT_W=16), measured from the rise-strobe cycle.
- Minimum period measured without ovr: CNT_W+8 cycles. Shorter periods set ovr, and only every other period (or fewer) is reported.
- valid is high for exactly 1 cycle. Outputs hold between valid pulses.
- Timeout valid comes 1 cycle after the TIMEOUT-th edgeless cycle.
- Same-cycle rise and timeout: rise wins and the timeout counter restarts.

## Test plan

1. Reset, then a synchronous PWM of 10 high / 30 low, repeating → after the second rise: high_cnt=10, period_cnt=40, duty_pct=25, valid 24 cycles after the rise strobe; stuck=0, ovr=0.
2. PWM of 1 high / 99 low, then 99 high / 1 low → duty_pct=1, then duty_pct=99; period_cnt=100 for both.
3. pwm_in held high for TIMEOUT+10 cycles (TIMEOUT overridden to 200 in the bench) → one valid, stuck=1, duty_pct=100, high_cnt=0, period_cnt=0. Held low instead → duty_pct=0. A following 50/50 PWM of period 100 → stuck=0, duty_pct=50.
4. PWM with a 12-cycle period (6/6) → ovr=1; valid pulses carry period_cnt=12, duty_pct=50; no valid spacing under 24 cycles.
5. clr asserted mid-MEAS_LO and, separately, mid-division → next cycle all outputs are 0, ovr=0, no valid from the aborted division; the first valid comes after two fresh rises.
6. rst_n pulsed asynchronously mid-division → outputs are 0 immediately, with no spurious valid after release.
